// File: rtl/vc_credit_tracker.sv
// rtl/vc_credit_tracker.sv - per-VC downstream credit counter and packet-ownership FSM; sticky error flags built only with VC_CREDIT_ERR_CHECK_EN
module vc_credit_tracker #(
    parameter int VC_NUM_PER_PORT   = 4,
    parameter int BUFFER_NUM_PER_VC = 4,
    parameter int FLIT_TYPE_WIDTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flit_wr,
    input  logic [VC_NUM_PER_PORT-1:0] flit_vc,
    input  logic [FLIT_TYPE_WIDTH-1:0] flit_type,
    input  logic                       credit_in,
    input  logic [VC_NUM_PER_PORT-1:0] credit_vc,
    output logic [VC_NUM_PER_PORT-1:0] vc_free,
    output logic [VC_NUM_PER_PORT-1:0] vc_credit_avail,
    output logic [VC_NUM_PER_PORT-1:0] vc_last_credit,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic                       err_protocol
);

    localparam int CNT_WIDTH = $clog2(BUFFER_NUM_PER_VC) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(BUFFER_NUM_PER_VC);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_BODY   = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_TAIL   = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HEAD   = FLIT_TYPE_WIDTH'(2);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_SINGLE = FLIT_TYPE_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } vc_state_e;

    vc_state_e            state_q [VC_NUM_PER_PORT];
    vc_state_e            state_d [VC_NUM_PER_PORT];
    logic [CNT_WIDTH-1:0] count_q [VC_NUM_PER_PORT];
    logic [CNT_WIDTH-1:0] count_d [VC_NUM_PER_PORT];

    logic [VC_NUM_PER_PORT-1:0] send;
    logic [VC_NUM_PER_PORT-1:0] ret;
    logic [VC_NUM_PER_PORT-1:0] underflow_hit;
    logic [VC_NUM_PER_PORT-1:0] overflow_hit;
    logic [VC_NUM_PER_PORT-1:0] protocol_hit;

    // per-VC send/return strobes from the one-hot selects
    always_comb begin
        send = '0;
        ret  = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            send[i] = flit_wr & flit_vc[i];
            ret[i]  = credit_in & credit_vc[i];
        end
    end

    // credit counter next state; simultaneous send+return on a VC cancels out, ends saturate
    always_comb begin
        underflow_hit = '0;
        overflow_hit  = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            count_d[i] = count_q[i];
            if (send[i] && !ret[i]) begin
                if (count_q[i] == CNT_ZERO) begin
                    underflow_hit[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] - CNT_ONE;
                end
            end else if (ret[i] && !send[i]) begin
                if (count_q[i] == CNT_MAX) begin
                    overflow_hit[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + CNT_ONE;
                end
            end
        end
    end

    // packet-ownership FSM next state; an illegal flit type flags an error and leaves state alone
    always_comb begin
        protocol_hit = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (send[i]) begin
                        if (flit_type == FT_HEAD) begin
                            state_d[i] = ST_ACTIVE;
                        end else if (flit_type == FT_SINGLE) begin
                            state_d[i] = ST_DRAIN;
                        end else begin
                            protocol_hit[i] = 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (send[i]) begin
                        if (flit_type == FT_TAIL) begin
                            state_d[i] = ST_DRAIN;
                        end else if (flit_type != FT_BODY) begin
                            protocol_hit[i] = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // release only once the registered count shows the downstream buffer empty
                    if (send[i]) begin
                        protocol_hit[i] = 1'b1;
                    end else if (count_q[i] == CNT_MAX) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // counter and FSM registers; reset discards any in-flight packet
    always_ff @(posedge clk) begin
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            if (reset) begin
                count_q[i] <= CNT_MAX;
                state_q[i] <= ST_IDLE;
            end else begin
                count_q[i] <= count_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // status decode from registered state only, so it lags the causing event by one cycle
    always_comb begin
        vc_free         = '0;
        vc_credit_avail = '0;
        vc_last_credit  = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            vc_free[i]         = (state_q[i] == ST_IDLE);
            vc_credit_avail[i] = (count_q[i] != CNT_ZERO);
            vc_last_credit[i]  = (count_q[i] == CNT_ONE);
        end
    end

`ifdef VC_CREDIT_ERR_CHECK_EN
    logic err_overflow_q;
    logic err_underflow_q;
    logic err_protocol_q;

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_protocol_q  <= 1'b0;
        end else begin
            err_overflow_q  <= err_overflow_q  | (|overflow_hit);
            err_underflow_q <= err_underflow_q | (|underflow_hit);
            err_protocol_q  <= err_protocol_q  | (|protocol_hit);
        end
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign err_protocol  = err_protocol_q;
`else
    logic err_hits_unused;
    assign err_hits_unused = |{overflow_hit, underflow_hit, protocol_hit};

    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
    assign err_protocol  = 1'b0;
`endif

`ifndef SYNTHESIS
    // simulation-only warning for non-one-hot VC selects
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (flit_wr && !$onehot(flit_vc)) begin
                $display("vc_credit_tracker: error: flit_vc %b not one-hot", flit_vc);
            end
            if (credit_in && !$onehot(credit_vc)) begin
                $display("vc_credit_tracker: error: credit_vc %b not one-hot", credit_vc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_credit_tracker.sv
// tb/tb_vc_credit_tracker.sv - directed self-checking bench for vc_credit_tracker
module tb_vc_credit_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       flit_wr;
    logic [3:0] flit_vc;
    logic [1:0] flit_type;
    logic       credit_in;
    logic [3:0] credit_vc;
    logic [3:0] vc_free;
    logic [3:0] vc_credit_avail;
    logic [3:0] vc_last_credit;
    logic       err_overflow;
    logic       err_underflow;
    logic       err_protocol;

    int errors = 0;
    int checks = 0;

`ifdef VC_CREDIT_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    vc_credit_tracker dut (
        .clk             (clk),
        .reset           (reset),
        .flit_wr         (flit_wr),
        .flit_vc         (flit_vc),
        .flit_type       (flit_type),
        .credit_in       (credit_in),
        .credit_vc       (credit_vc),
        .vc_free         (vc_free),
        .vc_credit_avail (vc_credit_avail),
        .vc_last_credit  (vc_last_credit),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow),
        .err_protocol    (err_protocol)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [3:0] f, input logic [3:0] a, input logic [3:0] l);
        chk({tag, ".free"},  {4'h0, vc_free},         {4'h0, f});
        chk({tag, ".avail"}, {4'h0, vc_credit_avail}, {4'h0, a});
        chk({tag, ".last"},  {4'h0, vc_last_credit},  {4'h0, l});
    endtask

    task automatic chk_err(input string tag, input logic o, input logic u, input logic p);
        chk({tag, ".ovf"},   {7'h0, err_overflow},  {7'h0, o});
        chk({tag, ".udf"},   {7'h0, err_underflow}, {7'h0, u});
        chk({tag, ".proto"}, {7'h0, err_protocol},  {7'h0, p});
    endtask

    task automatic send(input logic [3:0] vc, input logic [1:0] ft);
        flit_wr   = 1'b1;
        flit_vc   = vc;
        flit_type = ft;
    endtask

    task automatic ret(input logic [3:0] vc);
        credit_in = 1'b1;
        credit_vc = vc;
    endtask

    task automatic quiet();
        flit_wr   = 1'b0;
        flit_vc   = 4'h0;
        flit_type = 2'b00;
        credit_in = 1'b0;
        credit_vc = 4'h0;
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk_status("reset", 4'hF, 4'hF, 4'h0);
        chk_err("reset", 1'b0, 1'b0, 1'b0);

        // VC0 four-flit packet, no returns: count 4->3->2->1->0
        send(4'b0001, 2'b10); step();
        chk_status("vc0_head", 4'hE, 4'hF, 4'h0);
        send(4'b0001, 2'b00); step();
        chk_status("vc0_body1", 4'hE, 4'hF, 4'h0);
        send(4'b0001, 2'b00); step();
        chk_status("vc0_body2", 4'hE, 4'hF, 4'h1);
        send(4'b0001, 2'b01); step();
        quiet();
        chk_status("vc0_tail", 4'hE, 4'hE, 4'h0);
        chk_err("vc0_tail", 1'b0, 1'b0, 1'b0);

        // four credits back on VC0: count 0->4, free one cycle after full
        ret(4'b0001); step();
        chk_status("vc0_ret1", 4'hE, 4'hF, 4'h1);
        step();
        chk_status("vc0_ret2", 4'hE, 4'hF, 4'h0);
        step();
        step();
        quiet();
        chk_status("vc0_ret4", 4'hE, 4'hF, 4'h0);
        step();
        chk_status("vc0_release", 4'hF, 4'hF, 4'h0);
        chk_err("vc0_release", 1'b0, 1'b0, 1'b0);

        // VC2 single-flit with same-cycle return at count 4: count unchanged, no error
        send(4'b0100, 2'b11);
        ret(4'b0100);
        step();
        quiet();
        chk_status("vc2_single", 4'hB, 4'hF, 4'h0);
        chk_err("vc2_single", 1'b0, 1'b0, 1'b0);
        step();
        chk_status("vc2_release", 4'hF, 4'hF, 4'h0);

        // VC1 head plus VC3 return at full count: VC1=3, VC3 overflow
        send(4'b0010, 2'b10);
        ret(4'b1000);
        step();
        quiet();
        chk_status("vc1_vc3", 4'hD, 4'hF, 4'h0);
        chk_err("vc1_vc3", EXP_ERR, 1'b0, 1'b0);

        // drain VC1 to 0 with body flits, then one more body at 0
        send(4'b0010, 2'b00); step();
        send(4'b0010, 2'b00); step();
        chk_status("vc1_cnt1", 4'hD, 4'hF, 4'h2);
        send(4'b0010, 2'b00); step();
        chk_status("vc1_cnt0", 4'hD, 4'hD, 4'h0);
        chk_err("vc1_cnt0", EXP_ERR, 1'b0, 1'b0);
        send(4'b0010, 2'b00); step();
        quiet();
        chk_status("vc1_udf", 4'hD, 4'hD, 4'h0);
        chk_err("vc1_udf", EXP_ERR, EXP_ERR, 1'b0);
        step();
        chk_err("vc1_udf_hold", EXP_ERR, EXP_ERR, 1'b0);

        // body on idle VC2: protocol error, VC2 stays idle, count 4->3
        send(4'b0100, 2'b00); step();
        quiet();
        chk_status("vc2_proto", 4'hD, 4'hD, 4'h0);
        chk_err("vc2_proto", EXP_ERR, EXP_ERR, EXP_ERR);

        // reset clears everything
        reset = 1'b1; step();
        reset = 1'b0;
        chk_status("reset2", 4'hF, 4'hF, 4'h0);
        chk_err("reset2", 1'b0, 1'b0, 1'b0);

        // reset while VC0 is ACTIVE at count 1
        send(4'b0001, 2'b10); step();
        send(4'b0001, 2'b00); step();
        send(4'b0001, 2'b00); step();
        quiet();
        chk_status("vc0_active1", 4'hE, 4'hF, 4'h1);
        reset = 1'b1; step();
        reset = 1'b0;
        chk_status("midpkt_reset", 4'hF, 4'hF, 4'h0);
        step();
        chk_status("post_reset", 4'hF, 4'hF, 4'h0);
        chk_err("post_reset", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_credit_tracker.md
Name: vc_credit_tracker

Overview:
- Upstream-side counterpart of the per-port VC input buffer: sits at each router output port and tracks, per downstream VC, how many buffer slots remain free.
- Counts credits down on every flit sent and up on every credit returned, one per flit read from the downstream buffer.
- Runs a per-VC packet-ownership state machine so a VC is offered for allocation only when it is idle and fully drained.

Parameters:
- VC_NUM_PER_PORT, 4, number of VCs; all VC selects are one-hot of this width
- BUFFER_NUM_PER_VC, 4, downstream buffer depth per VC; initial and maximum credit count
- FLIT_TYPE_WIDTH, 2, width of the flit type field
- CNT_WIDTH, log2(BUFFER_NUM_PER_VC)+1, credit counter width (derived; do not override)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- flit_wr  in  1  flit sent downstream this cycle
- flit_vc  in  VC_NUM_PER_PORT  one-hot VC of the sent flit
- flit_type  in  FLIT_TYPE_WIDTH  2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single-flit (head+tail)
- credit_in  in  1  downstream buffer read one flit this cycle
- credit_vc  in  VC_NUM_PER_PORT  one-hot VC of the returned credit
- vc_free  out  VC_NUM_PER_PORT  VC is IDLE and may be allocated to a new packet
- vc_credit_avail  out  VC_NUM_PER_PORT  credit count > 0
- vc_last_credit  out  VC_NUM_PER_PORT  credit count == 1; the downstream buffer is nearly full
- err_overflow  out  1  sticky: credit returned while count == BUFFER_NUM_PER_VC
- err_underflow  out  1  sticky: flit sent while count == 0
- err_protocol  out  1  sticky: flit type illegal for VC state

Behaviour:
- Reset (synchronous, active-high): every count = BUFFER_NUM_PER_VC; every state = IDLE.
  - Outputs after reset: vc_free all 1, vc_credit_avail all 1, vc_last_credit all 0 (all 1 if BUFFER_NUM_PER_VC==1), err_* = 0.
  - Reset asserted mid-packet discards all in-flight state on that edge.
- Per-VC events: send[i] = flit_wr & flit_vc[i]; ret[i] = credit_in & credit_vc[i].
- Credit counter per VC, updated at the clock edge:
  - send & ~ret → count−1.
  - ret & ~send → count+1.
  - both or neither → unchanged.
  - Send and return on different VCs in the same cycle update independently.
  - Send at count 0 → count stays 0 (saturate) and sets err_underflow.
  - Return at count max → count stays at max and sets err_overflow.
- vc_free, vc_credit_avail and vc_last_credit are decoded combinationally from registered state and count only, never from current-cycle inputs. All status therefore has 1-cycle latency from the causing event.
- FSM per VC: IDLE, ACTIVE, DRAIN.
  - IDLE: send head → ACTIVE; send single-flit → DRAIN; send body or tail → err_protocol, state unchanged.
  - ACTIVE: send body → ACTIVE; send tail → DRAIN; send head or single-flit → err_protocol, state unchanged.
  - DRAIN: leave to IDLE on an edge where the registered count == BUFFER_NUM_PER_VC. Any send while in DRAIN → err_protocol, state unchanged.
  - Counter updates happen regardless of protocol errors.
- DRAIN release timing: a VC becomes free one cycle after its count returns to full. This guarantees the downstream buffer is empty before the VC is reallocated.
- Multi-hot or all-zero flit_vc with flit_wr=1, or credit_vc likewise with credit_in=1: behaviour undefined, with simulation-only $display of an error.

Optional Feature:
- Macro: VC_CREDIT_ERR_CHECK_EN.
- Defined: err_overflow, err_underflow and err_protocol are sticky registers, set as described above and cleared only by reset.
- Not defined: the three err ports are tied to 0 and no error registers are built. Counter saturation and the rule that protocol errors leave state unchanged still apply.

Test Plan:
- Reset, then idle 2 cycles → vc_free=4'hF, vc_credit_avail=4'hF, vc_last_credit=0, errors 0.
- VC0: head, body, body, tail on consecutive cycles, no returns → count 4→0, vc_last_credit[0]=1 after the 3rd flit, vc_credit_avail[0]=0 after the 4th, vc_free[0]=0 throughout.
- Continue: 4 credit returns on VC0 → count 0→4; vc_free[0] rises exactly 1 cycle after count reaches 4.
- Single-flit on VC2 with a simultaneous credit return on VC2 (count 4) → count stays 4, state DRAIN, vc_free[2]=1 two cycles later, no error. Separately, a same-cycle send on VC1 plus return on VC3 → VC1=3, VC3 overflow flagged.
- With the macro on: send on VC1 at count 0 → err_underflow=1 and holds; body flit on an IDLE VC → err_protocol=1; reset → both clear.
- Reset asserted while VC0 is ACTIVE with count 1 → next cycle count=4, vc_free[0]=1.
